// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Single-port memory arbiter between fetch (I) and load/store (D)
//               with D priority and a starvation counter guaranteeing I progress.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               r_resp_i;
    logic               r_resp_d;
    logic               w_grant_i;
    logic               w_grant_d;

    // D wins every conflict unless I has been denied STARVE_LIMIT times in a row.
    assign w_grant_i = i_req & (~d_req | (r_starve_cnt == c_LIMIT));
    assign w_grant_d = d_req & ~w_grant_i;

    assign i_ready   = w_grant_i;
    assign d_ready   = w_grant_d;
    assign mem_en    = (w_grant_i | w_grant_d) & ~rst;
    assign mem_we    = w_grant_d & d_we;
    assign mem_addr  = w_grant_i ? i_addr : d_addr;
    assign mem_wdata = d_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (i_req & ~w_grant_i) begin
            if (r_starve_cnt != c_LIMIT) begin
                r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // Writes complete at the accepting edge, so only reads arm a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_i <= 1'b0;
            r_resp_d <= 1'b0;
        end else begin
            r_resp_i <= w_grant_i;
            r_resp_d <= w_grant_d & ~d_we;
        end
    end

    assign i_rvalid = r_resp_i;
    assign i_rdata  = mem_rdata;
    assign d_rvalid = r_resp_d;
    assign d_rdata  = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a one-cycle-latency memory model.
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ready, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ready, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [0:63];
    int          errors = 0;
    int          checks = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:2]];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; i_addr = 32'h8;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (i_rvalid !== 1'b0) begin errors++; $display("FAIL rst_i_rvalid got=%b exp=0", i_rvalid); end
        checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL rst_d_rvalid got=%b exp=0", d_rvalid); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (d_ready !== 1'b1 || i_ready !== 1'b0) begin errors++; $display("FAIL rst_release_grant got d=%b i=%b exp d=1 i=0", d_ready, i_ready); end
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rst_release_mem_en got=%b exp=1", mem_en); end
        step();
        i_req = 1'b0; d_req = 1'b0;
        step();
    endtask

    task automatic test_lone_fetch();
        i_req = 1'b1; i_addr = 32'h8;
        @(negedge clk);
        checks++; if (i_ready !== 1'b1 || d_ready !== 1'b0) begin errors++; $display("FAIL fetch_ready got i=%b d=%b exp i=1 d=0", i_ready, d_ready); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_mem got en=%b we=%b exp en=1 we=0", mem_en, mem_we); end
        checks++; if (mem_addr !== 32'h8) begin errors++; $display("FAIL fetch_addr got=%h exp=00000008", mem_addr); end
        step();
        i_req = 1'b0;
        @(negedge clk);
        checks++; if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid got i=%b d=%b exp i=1 d=0", i_rvalid, d_rvalid); end
        checks++; if (i_rdata !== 32'h2402000A) begin errors++; $display("FAIL fetch_rdata got=%h exp=2402000a", i_rdata); end
        step();
        @(negedge clk);
        checks++; if (i_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid_single got=%b exp=0", i_rvalid); end
    endtask

    task automatic test_store_load();
        step();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (d_ready !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL store_accept got rdy=%b we=%b exp 1 1", d_ready, mem_we); end
        checks++; if (mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h10) begin errors++; $display("FAIL store_bus got addr=%h data=%h exp 00000010 deadbeef", mem_addr, mem_wdata); end
        step();
        d_we = 1'b0;
        @(negedge clk);
        checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL store_no_resp got=%b exp=0", d_rvalid); end
        checks++; if (mem_we !== 1'b0 || d_ready !== 1'b1) begin errors++; $display("FAIL load_accept got we=%b rdy=%b exp 0 1", mem_we, d_ready); end
        step();
        d_req = 1'b0;
        @(negedge clk);
        checks++; if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0) begin errors++; $display("FAIL load_rvalid got d=%b i=%b exp d=1 i=0", d_rvalid, i_rvalid); end
        checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got=%h exp=deadbeef", d_rdata); end
    endtask

    task automatic test_conflict();
        step();
        i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        @(negedge clk);
        checks++; if (d_ready !== 1'b1 || i_ready !== 1'b0) begin errors++; $display("FAIL conflict_grant got d=%b i=%b exp d=1 i=0", d_ready, i_ready); end
        step();
        d_req = 1'b0;
        checks++; if (dut.r_starve_cnt !== 3'd1) begin errors++; $display("FAIL conflict_starve got=%0d exp=1", dut.r_starve_cnt); end
        @(negedge clk);
        checks++; if (i_ready !== 1'b1 || d_ready !== 1'b0) begin errors++; $display("FAIL conflict_i_grant got i=%b d=%b exp i=1 d=0", i_ready, d_ready); end
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL conflict_d_resp got v=%b data=%h exp 1 deadbeef", d_rvalid, d_rdata); end
        step();
        i_req = 1'b0;
        checks++; if (dut.r_starve_cnt !== 3'd0) begin errors++; $display("FAIL conflict_starve_clr got=%0d exp=0", dut.r_starve_cnt); end
        @(negedge clk);
        checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h2402000A) begin errors++; $display("FAIL conflict_i_resp got v=%b data=%h exp 1 2402000a", i_rvalid, i_rdata); end
    endtask

    task automatic test_starvation();
        logic [9:0] exp_i;
        logic       prev_i;
        logic       prev_d;
        exp_i  = 10'b10000_10000;
        prev_i = 1'b0;
        prev_d = 1'b0;
        step();
        i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (i_ready !== exp_i[k] || d_ready !== ~exp_i[k]) begin errors++; $display("FAIL starve_grant[%0d] got i=%b d=%b exp i=%b", k, i_ready, d_ready, exp_i[k]); end
            checks++; if (i_rvalid !== prev_i || d_rvalid !== prev_d) begin errors++; $display("FAIL starve_rvalid[%0d] got i=%b d=%b exp i=%b d=%b", k, i_rvalid, d_rvalid, prev_i, prev_d); end
            if (prev_i) begin
                checks++; if (i_rdata !== 32'h2402000A) begin errors++; $display("FAIL starve_i_rdata[%0d] got=%h exp=2402000a", k, i_rdata); end
            end
            prev_i = exp_i[k];
            prev_d = ~exp_i[k];
            step();
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        checks++; if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin errors++; $display("FAIL starve_last_resp got i=%b d=%b exp i=1 d=0", i_rvalid, d_rvalid); end
    endtask

    task automatic test_reset_mid_read();
        step();
        i_req = 1'b1; i_addr = 32'h8;
        @(negedge clk);
        checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL midrst_accept got=%b exp=1", i_ready); end
        step();
        i_req = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++; if (i_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid got=%b exp=0", i_rvalid); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_spurious[%0d] got i=%b d=%b exp 0 0", k, i_rvalid, d_rvalid); end
        end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = '0;
        mem[2] = 32'h2402000A;
        test_reset();
        test_lone_fetch();
        test_store_load();
        test_conflict();
        test_starvation();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
